// File: rtl/rd_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rd_arb_pkg
// Brief   : Shared types and helpers for the per-master read-request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package rd_arb_pkg;

  localparam int NREQ = 2;

  typedef enum logic [2:0] {
    ARB  = 3'd0,
    POP  = 3'd1,
    LOAD = 3'd2,
    REQ  = 3'd3,
    RESP = 3'd4,
    RET  = 3'd5
  } State_e;

  function automatic logic [NREQ-1:0] grant_onehot(input logic g);
    logic [NREQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : rd_req_arbiter_if
// Brief   : Master-port read handshake (req/ack, resp/rdata) bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface rd_req_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) ();
  logic              m_req;
  logic [AWIDTH-1:0] m_addr;
  logic              m_cmd;
  logic              m_ack;
  logic              m_resp;
  logic [DWIDTH-1:0] m_rdata;

  modport master (output m_req, m_addr, m_cmd, input  m_ack, m_resp, m_rdata);
  modport slave  (input  m_req, m_addr, m_cmd, output m_ack, m_resp, m_rdata);
endinterface
`default_nettype wire

// File: rtl/rd_req_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter_2
// Brief   : Two-way round-robin pick; pointer remembers the last grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter_2
  import rd_arb_pkg::*;
(
  input  wire logic            aclk,
  input  wire logic            aresetn,
  input  wire logic [NREQ-1:0] req,
  input  wire logic            grant_en,
  output logic                 grant
);

  logic r_ptr;

  // With a single requester the pointer is irrelevant; with both, the other side wins.
  always_comb begin
    grant = ~r_ptr;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~r_ptr;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ptr <= 1'b1;
    end else if (grant_en) begin
      r_ptr <= grant;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rd_req_arbiter
// Brief   : Round-robin read scheduler, one outstanding read per master port.
// Revision: 1.0 - initial release
// ============================================================================
module rd_req_arbiter
  import rd_arb_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 15
) (
  input  wire logic              aclk,
  input  wire logic              aresetn,
  input  wire logic [NREQ-1:0]   fifo_empty,
  output logic      [NREQ-1:0]   fifo_rden,
  input  wire logic [AWIDTH-1:0] fifo_dout_0,
  input  wire logic [AWIDTH-1:0] fifo_dout_1,
  rd_req_arbiter_if.master       mbus,
  output logic      [DWIDTH-1:0] s_rdata,
  output logic      [NREQ-1:0]   s_resp,
  output logic      [NREQ-1:0]   s_err,
  output logic                   busy
);

  localparam int              c_TW    = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT - 1);

  State_e            r_state;
  State_e            w_next;
  logic              r_grant;
  logic              w_rr_grant;
  logic              w_grant_en;
  logic [NREQ-1:0]   w_req;
  logic [c_TW-1:0]   r_timer;
  logic              w_timeout;
  logic [AWIDTH-1:0] r_m_addr;
  logic [DWIDTH-1:0] r_s_rdata;
  logic [NREQ-1:0]   r_s_err;

  assign w_req      = ~fifo_empty;
  assign w_grant_en = (r_state == ARB) && (|w_req);
  assign w_timeout  = (r_state == RESP) && !mbus.m_resp && (r_timer == c_TLAST);

  rr_arbiter_2 u_rr (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req      (w_req),
    .grant_en (w_grant_en),
    .grant    (w_rr_grant)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ARB;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB:     if (|w_req) w_next = POP;
      POP:     w_next = LOAD;
      LOAD:    w_next = REQ;
      REQ:     if (mbus.m_ack) w_next = RESP;
      RESP: begin
        if (mbus.m_resp)    w_next = RET;
        else if (w_timeout) w_next = ARB;
      end
      RET:     w_next = ARB;
      default: w_next = ARB;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant   <= 1'b0;
      r_m_addr  <= '0;
      r_timer   <= '0;
      r_s_rdata <= '0;
      r_s_err   <= '0;
    end else begin
      if (w_grant_en) r_grant <= w_rr_grant;
      if (r_state == LOAD) r_m_addr <= r_grant ? fifo_dout_1 : fifo_dout_0;
      // Timer restarts on each RESP entry and saturates rather than wrapping.
      if ((r_state == REQ) && mbus.m_ack) begin
        r_timer <= '0;
      end else if ((r_state == RESP) && (r_timer != c_TLAST)) begin
        r_timer <= r_timer + 1'b1;
      end
      if ((r_state == RESP) && mbus.m_resp) r_s_rdata <= mbus.m_rdata;
      r_s_err <= w_timeout ? grant_onehot(r_grant) : '0;
    end
  end

  assign fifo_rden   = (r_state == POP) ? grant_onehot(r_grant) : '0;
  assign s_resp      = (r_state == RET) ? grant_onehot(r_grant) : '0;
  assign s_err       = r_s_err;
  assign s_rdata     = r_s_rdata;
  assign busy        = (r_state != ARB);
  assign mbus.m_req  = (r_state == REQ);
  assign mbus.m_addr = r_m_addr;
  assign mbus.m_cmd  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_rd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rd_req_arbiter
// Brief   : Directed self-checking bench for rd_req_arbiter (TIMEOUT = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rd_req_arbiter;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  fifo_empty;
  logic [1:0]  fifo_rden;
  logic [31:0] fifo_dout_0 = '0;
  logic [31:0] fifo_dout_1 = '0;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  logic [1:0]  s_err;
  logic        busy;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

  int vectors     = 0;
  int miscompares = 0;
  int resp_cnt0   = 0;
  int resp_cnt1   = 0;

  rd_req_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) mif ();

  rd_req_arbiter #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(4)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .fifo_empty  (fifo_empty),
    .fifo_rden   (fifo_rden),
    .fifo_dout_0 (fifo_dout_0),
    .fifo_dout_1 (fifo_dout_1),
    .mbus        (mif),
    .s_rdata     (s_rdata),
    .s_resp      (s_resp),
    .s_err       (s_err),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  // Request FIFO model: head appears the cycle after the pop strobe.
  assign fifo_empty = {(wp1 == rp1), (wp0 == rp0)};
  always @(posedge aclk) begin
    if (fifo_rden[0]) begin
      fifo_dout_0 <= mem0[rp0];
      rp0         <= rp0 + 1;
    end
    if (fifo_rden[1]) begin
      fifo_dout_1 <= mem1[rp1];
      rp1         <= rp1 + 1;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [31:0] a);
    mem0[wp0] = a;
    wp0++;
  endtask

  task automatic push1(input logic [31:0] a);
    mem1[wp1] = a;
    wp1++;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && mif.m_req !== 1'b1; i++) step();
    check({tag, "_req"}, 64'(mif.m_req), 64'd1);
  endtask

  task automatic do_read(input string tag, input int port, input logic [31:0] addr,
                         input int ackw, input int respw, input logic [31:0] data);
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    wait_req(tag);
    check({tag, "_addr"}, 64'(mif.m_addr), 64'(addr));
    repeat (ackw) step();
    mif.m_ack = 1'b1;
    step();
    mif.m_ack = 1'b0;
    check({tag, "_req_drop"}, 64'(mif.m_req), 64'd0);
    repeat (respw - 1) step();
    mif.m_resp  = 1'b1;
    mif.m_rdata = data;
    step();
    mif.m_resp = 1'b0;
    check({tag, "_resp"}, 64'(s_resp), 64'(oh));
    check({tag, "_rdata"}, 64'(s_rdata), 64'(data));
    if (s_resp[0]) resp_cnt0++;
    if (s_resp[1]) resp_cnt1++;
    step();
    check({tag, "_resp_end"}, 64'({s_resp, s_err}), 64'd0);
  endtask

  initial begin
    mif.m_ack   = 1'b0;
    mif.m_resp  = 1'b0;
    mif.m_rdata = '0;

    // Reset state
    repeat (3) step();
    check("rst_rden",  64'(fifo_rden), 64'd0);
    check("rst_req",   64'(mif.m_req), 64'd0);
    check("rst_addr",  64'(mif.m_addr), 64'd0);
    check("rst_cmd",   64'(mif.m_cmd), 64'd0);
    check("rst_rdata", 64'(s_rdata), 64'd0);
    check("rst_resp_err_busy", 64'({s_resp, s_err, busy}), 64'd0);
    aresetn = 1'b1;
    step();
    check("idle_busy", 64'(busy), 64'd0);

    // Single read with exact cycle positions (cycle n = push cycle)
    push0(32'h0000_0010);
    step();
    check("sr_rden_n1", 64'(fifo_rden), 64'd1);
    check("sr_busy_n1", 64'(busy), 64'd1);
    step();
    check("sr_rden_n2", 64'({fifo_rden, mif.m_req}), 64'd0);
    step();
    check("sr_req_n3",  64'(mif.m_req), 64'd1);
    check("sr_addr_n3", 64'(mif.m_addr), 64'h10);
    check("sr_cmd_n3",  64'(mif.m_cmd), 64'd0);
    step();
    step();
    check("sr_req_n5", 64'(mif.m_req), 64'd1);
    mif.m_ack = 1'b1;
    step();
    mif.m_ack = 1'b0;
    check("sr_req_n6", 64'(mif.m_req), 64'd0);
    check("sr_busy_n6", 64'(busy), 64'd1);
    step();
    step();
    mif.m_resp  = 1'b1;
    mif.m_rdata = 32'hCAFE_0001;
    check("sr_noresp_n8", 64'(s_resp), 64'd0);
    step();
    mif.m_resp = 1'b0;
    check("sr_resp_n9",  64'(s_resp), 64'd1);
    check("sr_rdata_n9", 64'(s_rdata), 64'hCAFE_0001);
    check("sr_err_n9",   64'(s_err), 64'd0);
    step();
    check("sr_end_n10",  64'({s_resp, busy}), 64'd0);
    check("sr_hold_rdata", 64'(s_rdata), 64'hCAFE_0001);

    // Spurious response while still in REQ
    push1(32'h0000_0030);
    wait_req("spur");
    mif.m_resp  = 1'b1;
    mif.m_rdata = 32'hDEAD_0000;
    step();
    mif.m_resp = 1'b0;
    check("spur_ignored", 64'(s_resp), 64'd0);
    check("spur_req_held", 64'(mif.m_req), 64'd1);
    do_read("spur", 1, 32'h0000_0030, 1, 2, 32'h0000_1234);

    // Fairness: pointer last granted port 1, so port 0 goes first
    resp_cnt0 = 0;
    resp_cnt1 = 0;
    for (int i = 0; i < 3; i++) begin
      push0(32'hA0 + 32'(i));
      push1(32'hB0 + 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      do_read($sformatf("fair%0d", i), i % 2,
              ((i % 2) != 0) ? (32'hB0 + 32'(i / 2)) : (32'hA0 + 32'(i / 2)),
              i % 3, 1 + (i % 2), 32'h5000 + 32'(i));
    end
    check("fair_cnt0", 64'(resp_cnt0), 64'd3);
    check("fair_cnt1", 64'(resp_cnt1), 64'd3);

    // Timeout: ack without response
    push0(32'h0000_0040);
    wait_req("to");
    check("to_addr", 64'(mif.m_addr), 64'h40);
    mif.m_ack = 1'b1;
    step();
    mif.m_ack = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("to_wait%0d", j), 64'({s_err, busy}), 64'd1);
      step();
    end
    check("to_err",  64'(s_err), 64'd1);
    check("to_busy", 64'({s_resp, busy}), 64'd0);
    step();
    check("to_err_end", 64'(s_err), 64'd0);
    push1(32'h0000_0050);
    do_read("after_to", 1, 32'h0000_0050, 0, 1, 32'hBEEF_0050);

    // Reset during RESP
    push0(32'h0000_0060);
    wait_req("rst_mid");
    mif.m_ack = 1'b1;
    step();
    mif.m_ack = 1'b0;
    step();
    aresetn = 1'b0;
    #1;
    check("rm_outs",  64'({fifo_rden, mif.m_req, s_resp, s_err, busy}), 64'd0);
    check("rm_addr",  64'(mif.m_addr), 64'd0);
    check("rm_rdata", 64'(s_rdata), 64'd0);
    step();
    step();
    check("rm_quiet", 64'({s_resp, s_err, busy}), 64'd0);
    push0(32'h0000_0070);
    push1(32'h0000_0080);
    aresetn = 1'b1;
    do_read("rst_p0", 0, 32'h0000_0070, 1, 3, 32'h7777_0070);
    do_read("rst_p1", 1, 32'h0000_0080, 2, 1, 32'h8888_0080);

    // Empty idle
    for (int j = 0; j < 100; j++) begin
      step();
      check("idle", 64'({fifo_rden, mif.m_req, busy}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
